// File: rtl/modem_pkg.sv
// modem_pkg: shared sample format, 16-QAM Gray level constants and mapper FSM states.
// Contents:
//   OUT_W                   output sample width (1s17)
//   LEVEL_A                 inner constellation magnitude (0.25 full scale)
//   LVL_M3/M1/P1/P3         -3A, -A, +A, +3A at OUT_W width
//   state_t                 mapper FSM states (IDLE, RUN)
package modem_pkg;

    localparam int OUT_W   = 18;
    localparam int LEVEL_A = 32768;

    localparam logic signed [OUT_W-1:0] LVL_M3 = OUT_W'(-3 * LEVEL_A);
    localparam logic signed [OUT_W-1:0] LVL_M1 = OUT_W'(-LEVEL_A);
    localparam logic signed [OUT_W-1:0] LVL_P1 = OUT_W'(LEVEL_A);
    localparam logic signed [OUT_W-1:0] LVL_P3 = OUT_W'(3 * LEVEL_A);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/pam4_level_map.sv
// pam4_level_map: combinational Gray-coded 2-bit to 4-level signed amplitude map.
// Ports:
//   sym    in  2      Gray-coded symbol bits
//   level  out OUT_W  signed amplitude: 00->-3A, 01->-A, 11->+A, 10->+3A
module pam4_level_map
    import modem_pkg::*;
(
    input  logic [1:0]              sym,
    output logic signed [OUT_W-1:0] level
);

    always_comb
        level = (sym == 2'b00) ? LVL_M3 :
                (sym == 2'b01) ? LVL_M1 :
                (sym == 2'b11) ? LVL_P1 : LVL_P3;

endmodule

// File: rtl/qam16_sym_mapper.sv
// qam16_sym_mapper: 16-QAM symbol mapper with zero-stuffing (or sample-and-hold) to the
// sample rate, symbol/sample strobe alignment monitoring and a symbol counter.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   sam_clk_ena        sample-rate enable pulse
//   sym_clk_ena        symbol-rate enable pulse (nominally every OSR-th sample)
//   sym_i, sym_q       Gray-coded 2-bit I/Q symbols, captured on sam & sym
//   out_i, out_q       signed 1s17 samples, registered, held between out_valid pulses
//   out_valid          one-clk pulse, one clk after each sam_clk_ena
//   sym_strobe         one-clk pulse with out_valid when the sample carries a symbol
//   phase              phase of the sample currently presented
//   locked             set by the first captured symbol
//   align_err          sticky strobe misalignment flag
//   sym_count          wrapping count of symbols emitted
module qam16_sym_mapper
    import modem_pkg::*;
#(
    parameter int  OSR        = 4,
    parameter bit  ZERO_STUFF = 1'b1,
    localparam int PW         = $clog2(OSR)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sam_clk_ena,
    input  logic                    sym_clk_ena,
    input  logic [1:0]              sym_i,
    input  logic [1:0]              sym_q,
    output logic signed [OUT_W-1:0] out_i,
    output logic signed [OUT_W-1:0] out_q,
    output logic                    out_valid,
    output logic                    sym_strobe,
    output logic [PW-1:0]           phase,
    output logic                    locked,
    output logic                    align_err,
    output logic [15:0]             sym_count
);

    state_t                  state, state_n;
    logic [PW-1:0]           ph, ph_n, ph_inc, phase_n;
    logic signed [OUT_W-1:0] map_i, map_q, last_i, last_q, last_i_n, last_q_n, out_i_n, out_q_n;
    logic                    strobe_n, locked_n, err_n;
    logic [15:0]             cnt_n;

    pam4_level_map u_map_i (.sym(sym_i), .level(map_i));
    pam4_level_map u_map_q (.sym(sym_q), .level(map_q));

    // ph is the phase expected for the next sample
    assign ph_inc = (ph == PW'(OSR - 1)) ? '0 : ph + PW'(1);

    always_comb begin
        state_n  = state;
        ph_n     = ph;
        phase_n  = phase;
        out_i_n  = out_i;
        out_q_n  = out_q;
        last_i_n = last_i;
        last_q_n = last_q;
        strobe_n = 1'b0;
        locked_n = locked;
        err_n    = align_err;
        cnt_n    = sym_count;
        if (sam_clk_ena) begin
            phase_n = '0;
            out_i_n = '0;
            out_q_n = '0;
            if (sym_clk_ena) begin
                // aligned or early symbol: either way emit it and restart the phase count
                if (state == RUN && ph != '0)
                    err_n = 1'b1;
                out_i_n  = map_i;
                out_q_n  = map_q;
                last_i_n = map_i;
                last_q_n = map_q;
                strobe_n = 1'b1;
                cnt_n    = sym_count + 16'd1;
                ph_n     = PW'(1);
                state_n  = RUN;
                locked_n = 1'b1;
            end else if (state == RUN) begin
                if (ph == '0) begin
                    // missing symbol: emit zero and carry on as if it had arrived
                    err_n = 1'b1;
                    ph_n  = PW'(1);
                end else begin
                    phase_n = ph;
                    ph_n    = ph_inc;
                    if (!ZERO_STUFF) begin
                        out_i_n = last_i;
                        out_q_n = last_q;
                    end
                end
            end
        end else if (sym_clk_ena && state == RUN) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ph         <= '0;
            phase      <= '0;
            out_i      <= '0;
            out_q      <= '0;
            last_i     <= '0;
            last_q     <= '0;
            out_valid  <= 1'b0;
            sym_strobe <= 1'b0;
            locked     <= 1'b0;
            align_err  <= 1'b0;
            sym_count  <= '0;
        end else begin
            state      <= state_n;
            ph         <= ph_n;
            phase      <= phase_n;
            out_i      <= out_i_n;
            out_q      <= out_q_n;
            last_i     <= last_i_n;
            last_q     <= last_q_n;
            out_valid  <= sam_clk_ena;
            sym_strobe <= strobe_n;
            locked     <= locked_n;
            align_err  <= err_n;
            sym_count  <= cnt_n;
        end
    end

endmodule

// File: tb/tb_qam16_sym_mapper.sv
// tb_qam16_sym_mapper: self-checking bench for qam16_sym_mapper (zero-stuff and hold variants).
module tb_qam16_sym_mapper;

    localparam int OSR = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sam_clk_ena = 1'b0;
    logic sym_clk_ena = 1'b0;
    logic [1:0] sym_i = 2'b00;
    logic [1:0] sym_q = 2'b00;

    logic signed [17:0] oi[2], oq[2];
    logic ov[2], ss[2], lk[2], ae[2];
    logic [1:0] oph[2];
    logic [15:0] sc[2];

    int checks = 0;
    int errors = 0;

    // reference model state: index 0 = zero-stuffing DUT, 1 = sample-and-hold DUT
    int zs[2] = '{1, 0};
    int e_i[2], e_q[2], e_v[2], e_s[2], e_ph[2];
    int m_lk[2], m_err[2], m_cnt[2], m_nx[2], m_li[2], m_lq[2];

    always #5 clk = ~clk;

    qam16_sym_mapper #(.OSR(OSR), .ZERO_STUFF(1'b1)) dut0 (
        .clk(clk), .reset(reset), .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena),
        .sym_i(sym_i), .sym_q(sym_q), .out_i(oi[0]), .out_q(oq[0]), .out_valid(ov[0]),
        .sym_strobe(ss[0]), .phase(oph[0]), .locked(lk[0]), .align_err(ae[0]), .sym_count(sc[0])
    );

    qam16_sym_mapper #(.OSR(OSR), .ZERO_STUFF(1'b0)) dut1 (
        .clk(clk), .reset(reset), .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena),
        .sym_i(sym_i), .sym_q(sym_q), .out_i(oi[1]), .out_q(oq[1]), .out_valid(ov[1]),
        .sym_strobe(ss[1]), .phase(oph[1]), .locked(lk[1]), .align_err(ae[1]), .sym_count(sc[1])
    );

    // Gray code -> natural index 0..3 -> odd-integer level times A
    function automatic int lvl(input logic [1:0] s);
        int idx;
        idx = (s[1] ? 2 : 0) + ((s[1] ^ s[0]) ? 1 : 0);
        return (2 * idx - 3) * 32768;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e_i[m] = 0; e_q[m] = 0; e_v[m] = 0; e_s[m] = 0; e_ph[m] = 0;
            m_lk[m] = 0; m_err[m] = 0; m_cnt[m] = 0; m_nx[m] = 0; m_li[m] = 0; m_lq[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input bit sam, input bit sym, input logic [1:0] si, input logic [1:0] sq);
        e_v[m] = sam;
        e_s[m] = 0;
        if (sam) begin
            e_ph[m] = 0; e_i[m] = 0; e_q[m] = 0;
            if (sym) begin
                if (m_lk[m] != 0 && m_nx[m] != 0) m_err[m] = 1;
                e_i[m] = lvl(si); e_q[m] = lvl(sq);
                m_li[m] = e_i[m]; m_lq[m] = e_q[m];
                e_s[m] = 1;
                m_cnt[m] = (m_cnt[m] + 1) % 65536;
                m_nx[m] = 1;
                m_lk[m] = 1;
            end else if (m_lk[m] != 0) begin
                if (m_nx[m] == 0) begin
                    m_err[m] = 1;
                    m_nx[m] = 1;
                end else begin
                    e_ph[m] = m_nx[m];
                    m_nx[m] = (m_nx[m] + 1) % OSR;
                    if (zs[m] == 0) begin
                        e_i[m] = m_li[m]; e_q[m] = m_lq[m];
                    end
                end
            end
        end else if (sym && m_lk[m] != 0) begin
            m_err[m] = 1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s[%0d] out_valid", tag, m), ov[m], e_v[m]);
            chk($sformatf("%s[%0d] out_i", tag, m), oi[m], e_i[m]);
            chk($sformatf("%s[%0d] out_q", tag, m), oq[m], e_q[m]);
            chk($sformatf("%s[%0d] sym_strobe", tag, m), ss[m], e_s[m]);
            chk($sformatf("%s[%0d] phase", tag, m), oph[m], e_ph[m]);
            chk($sformatf("%s[%0d] locked", tag, m), lk[m], m_lk[m]);
            chk($sformatf("%s[%0d] align_err", tag, m), ae[m], m_err[m]);
            chk($sformatf("%s[%0d] sym_count", tag, m), sc[m], m_cnt[m]);
        end
    endtask

    task automatic tick(input bit sam, input bit sym, input logic [1:0] si, input logic [1:0] sq,
                        input string tag, input bit do_chk = 1'b1);
        sam_clk_ena = sam;
        sym_clk_ena = sym;
        sym_i = si;
        sym_q = sq;
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_step(m, sam, sym, si, sq);
        #1;
        if (do_chk) check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        check_all(tag);
        reset = 1'b0;
    endtask

    typedef struct {
        bit         sym;
        logic [1:0] si;
        logic [1:0] sq;
        int         ei;
        int         eq;
        bit         estr;
        int         eph;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int lv_i[4] = '{-98304, -32768, 32768, 98304};
        int lv_q[4] = '{32768, 98304, -98304, -32768};
        logic [1:0] syms[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        int seq_ph[4] = '{1, 2, 3, 0};
        for (int k = 0; k < 16; k++) begin
            tbl[k].sym  = (k % 4 == 0);
            tbl[k].si   = syms[k / 4];
            tbl[k].sq   = ~syms[k / 4];
            tbl[k].ei   = (k % 4 == 0) ? lv_i[k / 4] : 0;
            tbl[k].eq   = (k % 4 == 0) ? lv_q[k / 4] : 0;
            tbl[k].estr = (k % 4 == 0);
            tbl[k].eph  = k % 4;
        end

        model_reset();
        do_reset("reset");

        // idle: samples without symbols produce zeros and no lock
        for (int k = 0; k < 12; k++) tick(k % 3 == 0, 1'b0, 2'b11, 2'b10, "idle");
        chk("idle locked", lk[0], 0);
        chk("idle align_err", ae[0], 0);
        chk("idle sym_count", sc[0], 0);

        // aligned Gray sweep from the table
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, tbl[k].sym, tbl[k].si, tbl[k].sq, "sweep");
            chk($sformatf("tbl%0d out_i", k), oi[0], tbl[k].ei);
            chk($sformatf("tbl%0d out_q", k), oq[0], tbl[k].eq);
            chk($sformatf("tbl%0d sym_strobe", k), ss[0], tbl[k].estr);
            chk($sformatf("tbl%0d phase", k), oph[0], tbl[k].eph);
        end
        chk("sweep sym_count", sc[0], 4);
        chk("sweep align_err", ae[0], 0);

        // sample-and-hold variant holds the symbol for the whole period
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, k == 0, 2'b10, 2'b00, "hold");
            chk($sformatf("hold%0d out_i", k), oi[1], 98304);
            chk($sformatf("hold%0d out_q", k), oq[1], -98304);
            chk($sformatf("hold%0d sym_strobe", k), ss[1], k == 0);
        end

        // early symbol at phase 2 realigns
        tick(1'b1, 1'b1, 2'b00, 2'b11, "early");
        tick(1'b1, 1'b0, 2'b00, 2'b11, "early");
        tick(1'b1, 1'b1, 2'b01, 2'b10, "early");
        chk("early align_err", ae[0], 1);
        chk("early out_i", oi[0], -32768);
        chk("early phase", oph[0], 0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, k == 3, 2'b11, 2'b11, "early_after");
            chk($sformatf("early_after%0d phase", k), oph[0], seq_ph[k]);
            chk($sformatf("early_after%0d align_err", k), ae[0], 1);
        end

        // missing symbol at phase 0
        do_reset("reset2");
        tick(1'b1, 1'b1, 2'b10, 2'b10, "miss");
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 2'b10, 2'b10, "miss");
        chk("miss pre align_err", ae[0], 0);
        tick(1'b1, 1'b0, 2'b10, 2'b10, "miss");
        chk("miss align_err", ae[0], 1);
        chk("miss out_i", oi[0], 0);
        chk("miss sym_strobe", ss[0], 0);
        chk("miss sym_count", sc[0], 1);
        do_reset("reset3");
        chk("reset3 locked", lk[0], 0);
        chk("reset3 align_err", ae[0], 0);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++)
            tick($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rand");

        // counter wrap: 65536 symbols back to back
        do_reset("reset4");
        for (int k = 0; k < 65536; k++)
            tick(1'b1, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "wrap", 1'b0);
        check_all("wrap");
        chk("wrap sym_count0", sc[0], 0);
        chk("wrap sym_count1", sc[1], 0);

        // reset mid-symbol at phase 2 discards the in-flight sample
        tick(1'b1, 1'b0, 2'b10, 2'b10, "mid");
        tick(1'b1, 1'b0, 2'b10, 2'b10, "mid");
        chk("mid phase", oph[0], 2);
        sam_clk_ena = 1'b1;
        sym_clk_ena = 1'b1;
        do_reset("midreset");
        chk("midreset out_valid", ov[0], 0);
        chk("midreset out_i", oi[1], 0);
        chk("midreset locked", lk[0], 0);
        chk("midreset align_err", ae[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
